// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory-side line-transfer responder: state encoding,
// line geometry defaults, beat strobe table and address-to-line mapping.
package mem_if_pkg;

    localparam int MEM_WORDS_PER_LINE = 4;
    localparam int OFFSET_BITS        = 2 + $clog2(MEM_WORDS_PER_LINE);

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_ACK  = 3'd1;
    localparam state_t ST_WAIT = 3'd2;
    localparam state_t ST_BEAT = 3'd3;
    localparam state_t ST_FIN  = 3'd4;

    // ACK_DATA strobe for beat i of a default-sized line
    localparam logic [MEM_WORDS_PER_LINE-1:0] ACK_ONEHOT [MEM_WORDS_PER_LINE] =
        '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    // Drops the in-line byte offset and keeps only as many index bits as the
    // storage holds, so upper address bits alias onto lower lines.
    function automatic logic [63:0] line_index(input logic [63:0] addr,
                                               input int offset_bits,
                                               input int index_bits);
        logic [63:0] mask;
        mask = (64'd1 << index_bits) - 64'd1;
        return (addr >> offset_bits) & mask;
    endfunction

endpackage

// File: rtl/mem_line_array.sv
// Line storage: DEPTH_LINES x WORDS_PER_LINE words, one synchronous write port and
// one combinational read port, both addressed by (line, beat).
module mem_line_array #(
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int DEPTH_LINES    = 256,
    parameter int LINE_W         = 8,
    parameter int BEAT_W         = 2
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [LINE_W-1:0] wr_line,
    input  logic [BEAT_W-1:0] wr_beat,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [LINE_W-1:0] rd_line,
    input  logic [BEAT_W-1:0] rd_beat,
    output logic [DATA_W-1:0] rd_data
);

    localparam int ENTRIES = DEPTH_LINES * WORDS_PER_LINE;
    localparam int AW      = LINE_W + BEAT_W;

    logic [DATA_W-1:0] mem_array [ENTRIES];
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;

    // Both dimensions are powers of two, so {line, beat} is a dense word address.
    assign wr_addr = {wr_line, wr_beat};
    assign rd_addr = {rd_line, rd_beat};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_array[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_array[rd_addr];

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side responder for the L1 line-transfer protocol: accepts one LOAD (fill)
// or STORE (write-back) at a time, waits LATENCY cycles, then moves one word per beat.
module mem_line_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = MEM_WORDS_PER_LINE,
    parameter int DEPTH_LINES    = 256,
    parameter int LATENCY        = 3
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      VALID,
    output logic                      READY,
    input  logic                      LOAD,
    input  logic                      STORE,
    input  logic [ADDR_W-1:0]         ADDR,
    output logic                      ACK_ADDR,
    input  logic [DATA_W-1:0]         WDATA,
    output logic [DATA_W-1:0]         RDATA,
    output logic [WORDS_PER_LINE-1:0] ACK_DATA,
    output logic                      DONE,
    output logic                      ERR
);

    localparam int OFF_BITS  = 2 + $clog2(WORDS_PER_LINE);
    localparam int LINE_W    = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
    localparam int BEAT_W    = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int WAIT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int WAIT_LAST = (LATENCY > 0) ? LATENCY - 1 : 0;

    state_t              state_reg, state_next;
    logic                load_op_reg, load_op_next;
    logic [LINE_W-1:0]   line_reg, line_next;
    logic [BEAT_W-1:0]   beat_reg, beat_next;
    logic [WAIT_W-1:0]   wait_reg, wait_next;
    logic                err_reg, err_next;
    logic [DATA_W-1:0]   rd_word;
    logic [WORDS_PER_LINE-1:0] beat_onehot;
    logic                in_beat;
    logic                wr_en;

    always_comb begin
        state_next   = state_reg;
        load_op_next = load_op_reg;
        line_next    = line_reg;
        beat_next    = beat_reg;
        wait_next    = wait_reg;
        err_next     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (VALID) begin
                    if (LOAD ^ STORE) begin
                        state_next   = ST_ACK;
                        load_op_next = LOAD;
                        line_next    = LINE_W'(line_index(64'(ADDR), OFF_BITS, LINE_W));
                    end else begin
                        // Ambiguous opcode: flag it and stay available.
                        err_next = 1'b1;
                    end
                end
            end
            ST_ACK: begin
                beat_next  = '0;
                wait_next  = '0;
                state_next = (LATENCY > 0) ? ST_WAIT : ST_BEAT;
            end
            ST_WAIT: begin
                if (wait_reg == WAIT_W'(WAIT_LAST)) begin
                    state_next = ST_BEAT;
                end else begin
                    wait_next = wait_reg + 1'b1;
                end
            end
            ST_BEAT: begin
                if (beat_reg == BEAT_W'(WORDS_PER_LINE - 1)) begin
                    state_next = ST_FIN;
                end else begin
                    beat_next = beat_reg + 1'b1;
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg   <= ST_IDLE;
            load_op_reg <= 1'b0;
            line_reg    <= '0;
            beat_reg    <= '0;
            wait_reg    <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            load_op_reg <= load_op_next;
            line_reg    <= line_next;
            beat_reg    <= beat_next;
            wait_reg    <= wait_next;
            err_reg     <= err_next;
        end
    end

    generate
        if (WORDS_PER_LINE == MEM_WORDS_PER_LINE) begin : g_strobe_table
            assign beat_onehot = ACK_ONEHOT[beat_reg];
        end else begin : g_strobe_decode
            for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_bit
                assign beat_onehot[gi] = (beat_reg == BEAT_W'(gi));
            end
        end
    endgenerate

    assign in_beat = (state_reg == ST_BEAT);
    // A STORE beat commits at the edge closing it; an async reset mid-line stops the rest.
    assign wr_en   = in_beat && !load_op_reg;

    mem_line_array #(
        .DATA_W         (DATA_W),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .DEPTH_LINES    (DEPTH_LINES),
        .LINE_W         (LINE_W),
        .BEAT_W         (BEAT_W)
    ) u_array (
        .clk     (CLK),
        .wr_en   (wr_en),
        .wr_line (line_reg),
        .wr_beat (beat_reg),
        .wr_data (WDATA),
        .rd_line (line_reg),
        .rd_beat (beat_reg),
        .rd_data (rd_word)
    );

    assign READY    = (state_reg == ST_IDLE);
    assign ACK_ADDR = (state_reg == ST_ACK);
    assign DONE     = (state_reg == ST_FIN);
    assign ERR      = err_reg;
    assign ACK_DATA = in_beat ? beat_onehot : '0;
    assign RDATA    = (in_beat && load_op_reg) ? rd_word : '0;

endmodule

// File: doc/mem_line_responder.md
Name: mem_line_responder

Overview:
- Memory-side responder for the L1 data-cache line-transfer protocol (VALID/READY request, ACK_ADDR address acknowledge, one-hot ACK_DATA beat strobes).
- Accepts one line request at a time:
  - LOAD = line fill: memory returns 4 words to the cache.
  - STORE = write-back: the cache delivers 4 words to memory.
- Holds line storage internally, models a fixed access latency, and sits opposite l1_dcache inside the memory subsystem.

Parameters:
ADDR_W, 32, request address width (byte address)
DATA_W, 32, word width
WORDS_PER_LINE, 4, beats per line; ACK_DATA width
DEPTH_LINES, 256, lines of storage (power of two)
LATENCY, 3, wait cycles between ACK_ADDR and first data beat (0 allowed)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
VALID  in  1  cache request valid
READY  out  1  responder idle, can accept request
LOAD  in  1  request is line fill (sampled with VALID)
STORE  in  1  request is write-back (sampled with VALID)
ADDR  in  ADDR_W  byte address of line (offset bits ignored)
ACK_ADDR  out  1  one-cycle pulse: request latched
WDATA  in  DATA_W  write-back word, held by cache for beat i while ACK_DATA[i]=1
RDATA  out  DATA_W  fill word for beat i while ACK_DATA[i]=1, else 0
ACK_DATA  out  WORDS_PER_LINE  one-hot beat strobe; all-zero outside beats
DONE  out  1  one-cycle pulse after last beat
ERR  out  1  one-cycle pulse: malformed request rejected

Behaviour:
- Clocking and reset:
  - One clock, CLK. RST_N is asynchronous and active-low.
  - Reset values: READY=1, ACK_ADDR=0, ACK_DATA=0, RDATA=0, DONE=0, ERR=0, state IDLE, beat counter 0, wait counter 0.
  - Storage array is not reset. Simulation initial contents are zero.
- States: IDLE, ACK, WAIT, BEAT, FIN.
- IDLE:
  - READY=1.
  - Accept on VALID & READY with exactly one of LOAD/STORE. Latch op, and line index = ADDR[ADDR_W-1 : 2+log2(WORDS_PER_LINE)] modulo DEPTH_LINES (upper bits wrap). Go to ACK.
  - VALID with LOAD=STORE (both or neither): ERR pulses the next cycle, state stays IDLE, READY stays 1.
- ACK: ACK_ADDR=1 for exactly this cycle, READY=0. Go to WAIT if LATENCY>0, else BEAT.
- WAIT: counts LATENCY cycles, then BEAT.
- BEAT: WORDS_PER_LINE consecutive cycles, beat i=0..WORDS_PER_LINE-1 in order, no wrap-first reordering.
  - ACK_DATA = 1<<i.
  - LOAD: RDATA = mem[line][i], combinational read of the registered index.
  - STORE: mem[line][i] <= WDATA at the end of the cycle.
- FIN: DONE=1 for one cycle, READY still 0. Next cycle IDLE, READY=1.
- Cycle timing (accept edge = cycle 0):
  - ACK_ADDR at cycle 1.
  - Beats at cycles 2+LATENCY .. 1+LATENCY+WORDS_PER_LINE.
  - DONE at 2+LATENCY+WORDS_PER_LINE; READY back one cycle later.
  - LATENCY=3: beats 5..8, DONE 9, READY 10.
- Simultaneous and illegal inputs:
  - Inputs VALID/LOAD/STORE/ADDR are ignored outside IDLE. Deasserting VALID mid-transaction does not abort.
  - A STORE immediately followed by a LOAD to the same line returns the newly written data; the write completes before READY is reasserted.
- Reset mid-transaction:
  - Immediate return to IDLE with reset output values.
  - Store beats already written stay written; remaining beats are not written.
  - No DONE is produced.

Decomposition:
- Package mem_if_pkg:
  - State enum.
  - WORDS_PER_LINE default.
  - OFFSET_BITS = 2+log2(WORDS_PER_LINE).
  - Line-index extraction function.
  - ACK_DATA one-hot constants.
- Sub-module mem_line_array: DEPTH_LINES×WORDS_PER_LINE words, one synchronous write port, one combinational read port, indexed by (line, beat). The responder FSM and counters stay in mem_line_responder.

Test Plan:
- STORE line 0x0000_0040 with WDATA A0,A1,A2,A3 (LATENCY=3) -> ACK_ADDR at cycle 1; ACK_DATA 0001,0010,0100,1000 at cycles 5..8; DONE at 9; READY=1 at 10.
- LOAD 0x0000_004C right after the previous store -> same line (offset ignored); RDATA A0..A3 with ACK_DATA 0001..1000 at cycles 5..8; RDATA=0 at all other cycles.
- VALID with LOAD=STORE=1, and separately with both 0 -> ERR pulses one cycle each time; ACK_ADDR never asserts; READY stays 1.
- LATENCY=0 build, LOAD -> ACK_ADDR at cycle 1; beats at cycles 2..5; DONE at 6.
- Aliasing: STORE to line index DEPTH_LINES+3, then LOAD line 3 -> returns the stored words (upper address bits wrap).
- Reset mid-transaction: RST_N low during beat 2 of a STORE -> outputs go to reset values immediately. A subsequent LOAD of that line returns new words for beats 0-1 and old contents for beats 2-3; no DONE for the aborted request.
